stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, 15, maximum wait cycles in FETCH for imem_ack_i before FAULT.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req_o  out  1  instruction fetch request.
REQ-006 imem_addr_o  out  32  fetch address, equal to the current PC.
REQ-007 imem_ack_i  in  1  fetch complete; imem_data_i valid this cycle.
REQ-008 imem_data_i  in  32  fetched instruction word.
REQ-009 ir_o  out  32  latched instruction, drives the ALU ir_i input.
REQ-010 itype_i  in  5  decoded instruction class for ir_o, from the decoder.
REQ-011 stage_o  out  3  current stage, drives the ALU stage_i input.
REQ-012 readin_a_o, readin_b_o, readin_pass_o  out  1 each  operand capture strobes to the ALU.
REQ-013 wb_en_o  out  1  register-file write enable for y_o.
REQ-014 halt_i  in  1  stop request, sampled at end of WRITEBACK.
REQ-015 illegal_o  out  1  sticky flag: unsupported itype seen.
REQ-016 fault_o  out  1  sticky flag: fetch timeout.
REQ-017 retire_cnt_o  out  32  retired instruction count.

Function
REQ-018 The FSM SHALL use these states, with stage_o encoding: FETCH=0, DECODE=1, READ=2, EXECUTE=3, WRITEBACK=4, HALT=5, FAULT=6.
REQ-019 FETCH SHALL hold imem_req_o=1 and imem_addr_o=PC; on imem_ack_i=1 it SHALL latch imem_data_i into ir_o, drop imem_req_o on the same edge, and enter DECODE.
REQ-020 Any FETCH cycle without an ack SHALL increment the wait counter; reaching FETCH_TIMEOUT with no ack SHALL set fault_o, drop imem_req_o, and enter FAULT; ack and timeout in the same cycle SHALL resolve as ack.
REQ-021 imem_ack_i outside FETCH SHALL be ignored.
REQ-022 DECODE SHALL last 1 cycle; itype_i RTYPE or ITYPE SHALL go to READ; any other value SHALL set illegal_o and go to WRITEBACK with wb_en_o=0.
REQ-023 READ SHALL last 1 cycle with readin_a_o, readin_b_o and readin_pass_o all 1 (registered); all three SHALL be 0 in every other state, giving one rising edge per instruction.
REQ-024 EXECUTE SHALL last exactly 1 cycle (stage_o=3) and then go to WRITEBACK.
REQ-025 WRITEBACK SHALL last 1 cycle, assert wb_en_o=1 only for legal instructions, set PC to PC+4 (mod 2^32 wrap), and increment retire_cnt_o (wraps to 0 after 32'hFFFF_FFFF, illegal instructions included).
REQ-026 At the end of WRITEBACK, halt_i=1 SHALL enter HALT; otherwise the FSM SHALL enter FETCH.
REQ-027 HALT SHALL stay while halt_i=1 and enter FETCH in the cycle after halt_i=0.
REQ-028 FAULT SHALL be terminal until reset.
REQ-029 Best-case latency SHALL be 5 cycles per instruction when ack arrives in the first FETCH cycle.

Reset
REQ-030 reset SHALL have priority over every transition, including mid-fetch, where imem_req_o drops on that edge.
REQ-031 While reset=1: state=FETCH, PC=RESET_PC, ir_o=0, retire_cnt_o=0, imem_req_o=0, all strobes=0, wb_en_o=0, illegal_o=0, fault_o=0, wait counter=0, stage_o=0.
REQ-032 imem_req_o SHALL assert in the first cycle after reset deasserts.

Structure
REQ-033 Stage encodings SHALL be in the shared constants file alongside the existing itype and opcode codes (RTYPE, ITYPE, UTYPE).
REQ-034 The fetch wait counter SHALL be a sub-module, fetch_timer (clear, enable, expired output).

Verification
REQ-035 Reset release, ack in the first FETCH cycle, ir=ADD R-type, itype=RTYPE -> stage_o sequence 0,1,2,3,4,0; wb_en_o=1 for one cycle; PC 0->4; retire_cnt_o=1.
REQ-036 Ack delayed 3 cycles -> imem_req_o high for 4 cycles, ir_o=imem_data_i at the ack edge, total 8 cycles to return to FETCH.
REQ-037 No ack for 15 cycles -> fault_o=1, stage_o=6, imem_req_o=0, held until reset.
REQ-038 itype=UTYPE -> stage_o 1->4, no readin strobe, wb_en_o=0, illegal_o=1, PC+4.
REQ-039 halt_i=1 during WRITEBACK -> stage_o=5; halt_i low -> FETCH next cycle at the updated PC.
REQ-040 reset asserted during READ -> next cycle all outputs match REQ-031, and PC=RESET_PC.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: stage encodings, instruction classes and opcodes shared by the sequencer
package stage_sequencer_pkg;
   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_READ      = 3'd2;
   localparam logic [2:0] ST_EXECUTE   = 3'd3;
   localparam logic [2:0] ST_WRITEBACK = 3'd4;
   localparam logic [2:0] ST_HALT      = 3'd5;
   localparam logic [2:0] ST_FAULT     = 3'd6;

   localparam logic [4:0] RTYPE = 5'b00001;
   localparam logic [4:0] ITYPE = 5'b00010;
   localparam logic [4:0] UTYPE = 5'b00100;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   function automatic logic is_supported(input logic [4:0] t);
      return (t == RTYPE) || (t == ITYPE);
   endfunction
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts consecutive un-acked fetch cycles and flags the last allowed one
module fetch_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] cnt_q;
   // wait counter: clear wins over count
   always_ff @(posedge clk)
      cnt_q <= clear_i ? '0 : enable_i ? cnt_q + 1'b1 : cnt_q;
   assign expired_o = (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle fetch/decode/read/execute/writeback control FSM
module stage_sequencer
   import stage_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          FETCH_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] ir_o,
   input  logic [4:0]  itype_i,
   output logic [2:0]  stage_o,
   output logic        readin_a_o,
   output logic        readin_b_o,
   output logic        readin_pass_o,
   output logic        wb_en_o,
   input  logic        halt_i,
   output logic        illegal_o,
   output logic        fault_o,
   output logic [31:0] retire_cnt_o
);
   logic [2:0]  state_q, state_d;
   logic        req_q, req_d, rd_q, rd_d, wb_q, wb_d, ill_q, ill_d, flt_q, flt_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, ret_q, ret_d;
   logic        fetch_wait, expired;

   // a fetch is only live once req is up; the idle FETCH cycle after reset neither waits nor accepts acks
   assign fetch_wait = (state_q == ST_FETCH) && req_q && !imem_ack_i;

   fetch_timer #(.TIMEOUT(FETCH_TIMEOUT)) u_timer (
      .clk       (clk),
      .clear_i   (reset || !fetch_wait),
      .enable_i  (fetch_wait),
      .expired_o (expired)
   );

   // next-state logic; strobes and req are registered so they are computed for the coming state
   always_comb begin
      state_d = state_q;
      req_d   = 1'b0;
      rd_d    = 1'b0;
      wb_d    = 1'b0;
      ir_d    = ir_q;
      pc_d    = pc_q;
      ret_d   = ret_q;
      ill_d   = ill_q;
      flt_d   = flt_q;
      case (state_q)
         ST_FETCH: begin
            if (req_q && imem_ack_i) begin
               ir_d    = imem_data_i;
               state_d = ST_DECODE;
            end else if (req_q && expired) begin
               flt_d   = 1'b1;
               state_d = ST_FAULT;
            end else begin
               req_d = 1'b1;
            end
         end
         ST_DECODE: begin
            state_d = is_supported(itype_i) ? ST_READ : ST_WRITEBACK;
            rd_d    = is_supported(itype_i);
            ill_d   = ill_q || !is_supported(itype_i);
         end
         ST_READ: state_d = ST_EXECUTE;
         ST_EXECUTE: begin
            state_d = ST_WRITEBACK;
            wb_d    = 1'b1;
         end
         ST_WRITEBACK: begin
            pc_d    = pc_q + 32'd4;
            ret_d   = ret_q + 32'd1;
            state_d = halt_i ? ST_HALT : ST_FETCH;
            req_d   = !halt_i;
         end
         ST_HALT: begin
            state_d = halt_i ? ST_HALT : ST_FETCH;
            req_d   = !halt_i;
         end
         ST_FAULT: state_d = ST_FAULT;
         default: state_d = ST_FETCH;
      endcase
   end

   // state registers with synchronous reset taking priority over every transition
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         req_q   <= 1'b0;
         rd_q    <= 1'b0;
         wb_q    <= 1'b0;
         ir_q    <= '0;
         pc_q    <= RESET_PC;
         ret_q   <= '0;
         ill_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rd_q    <= rd_d;
         wb_q    <= wb_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         ret_q   <= ret_d;
         ill_q   <= ill_d;
         flt_q   <= flt_d;
      end
   end

   assign imem_req_o    = req_q;
   assign imem_addr_o   = pc_q;
   assign ir_o          = ir_q;
   assign stage_o       = state_q;
   assign readin_a_o    = rd_q;
   assign readin_b_o    = rd_q;
   assign readin_pass_o = rd_q;
   assign wb_en_o       = wb_q;
   assign illegal_o     = ill_q;
   assign fault_o       = flt_q;
   assign retire_cnt_o  = ret_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed-vector bench for the stage sequencer
module tb_stage_sequencer;
   import stage_sequencer_pkg::*;

   logic        clk = 1'b0, reset = 1'b1, imem_ack_i = 1'b0, halt_i = 1'b0;
   logic [31:0] imem_data_i = '0;
   logic [4:0]  itype_i = RTYPE;
   logic        imem_req_o, readin_a_o, readin_b_o, readin_pass_o, wb_en_o, illegal_o, fault_o;
   logic [31:0] imem_addr_o, ir_o, retire_cnt_o;
   logic [2:0]  stage_o;
   int vectors = 0, miscompares = 0;

   localparam logic [31:0] ADD  = 32'h0020_81B3;
   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [31:0] LUI  = 32'h1234_52B7;

   stage_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(15)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_data_i   (imem_data_i),
      .ir_o          (ir_o),
      .itype_i       (itype_i),
      .stage_o       (stage_o),
      .readin_a_o    (readin_a_o),
      .readin_b_o    (readin_b_o),
      .readin_pass_o (readin_pass_o),
      .wb_en_o       (wb_en_o),
      .halt_i        (halt_i),
      .illegal_o     (illegal_o),
      .fault_o       (fault_o),
      .retire_cnt_o  (retire_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // packs {stage, req, readin_a, readin_b, readin_pass, wb_en}
   task automatic chk_st(input string tag, input logic [2:0] st, input logic req, input logic rd, input logic wb);
      chk(tag, {24'd0, stage_o, imem_req_o, readin_a_o, readin_b_o, readin_pass_o, wb_en_o},
               {24'd0, st, req, rd, rd, rd, wb});
   endtask

   initial begin
      tick;
      tick;
      chk_st("rst_ctl", ST_FETCH, 0, 0, 0);
      chk("rst_pc", imem_addr_o, 32'h0);
      chk("rst_ir", ir_o, 32'h0);
      chk("rst_ret", retire_cnt_o, 32'h0);
      chk("rst_flags", {30'd0, illegal_o, fault_o}, 32'h0);
      reset = 1'b0;
      tick;
      chk_st("req_after_rst", ST_FETCH, 1, 0, 0);
      // single-cycle ack, R-type
      imem_data_i = ADD; imem_ack_i = 1'b1; itype_i = RTYPE;
      tick;
      chk_st("t1_dec", ST_DECODE, 0, 0, 0);
      chk("t1_ir", ir_o, ADD);
      imem_ack_i = 1'b0;
      tick; chk_st("t1_read", ST_READ, 0, 1, 0);
      tick; chk_st("t1_exe", ST_EXECUTE, 0, 0, 0);
      tick; chk_st("t1_wb", ST_WRITEBACK, 0, 0, 1);
      tick; chk_st("t1_fetch", ST_FETCH, 1, 0, 0);
      chk("t1_pc", imem_addr_o, 32'h4);
      chk("t1_ret", retire_cnt_o, 32'd1);
      // ack delayed three cycles; a stray ack in DECODE must be ignored
      imem_data_i = ADDI; itype_i = ITYPE;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_st("t2_wait", ST_FETCH, 1, 0, 0);
      end
      imem_ack_i = 1'b1;
      tick; chk_st("t2_dec", ST_DECODE, 0, 0, 0);
      chk("t2_ir", ir_o, ADDI);
      imem_data_i = 32'hDEAD_BEEF;
      tick; chk_st("t2_read", ST_READ, 0, 1, 0);
      chk("t2_ir_hold", ir_o, ADDI);
      imem_ack_i = 1'b0;
      tick; tick;
      chk_st("t2_wb", ST_WRITEBACK, 0, 0, 1);
      tick; chk_st("t2_fetch", ST_FETCH, 1, 0, 0);
      chk("t2_pc", imem_addr_o, 32'h8);
      chk("t2_ret", retire_cnt_o, 32'd2);
      // unsupported class skips READ/EXECUTE
      imem_data_i = LUI; itype_i = UTYPE; imem_ack_i = 1'b1;
      tick; chk_st("t3_dec", ST_DECODE, 0, 0, 0);
      imem_ack_i = 1'b0;
      tick; chk_st("t3_wb", ST_WRITEBACK, 0, 0, 0);
      chk("t3_ill", {31'd0, illegal_o}, 32'd1);
      tick; chk_st("t3_fetch", ST_FETCH, 1, 0, 0);
      chk("t3_pc", imem_addr_o, 32'hC);
      chk("t3_ret", retire_cnt_o, 32'd3);
      chk("t3_ill_sticky", {31'd0, illegal_o}, 32'd1);
      // halt at writeback
      imem_data_i = ADD; itype_i = RTYPE; imem_ack_i = 1'b1;
      tick; imem_ack_i = 1'b0;
      tick; tick; tick;
      chk_st("t4_wb", ST_WRITEBACK, 0, 0, 1);
      halt_i = 1'b1;
      tick; chk_st("t4_halt", ST_HALT, 0, 0, 0);
      chk("t4_pc", imem_addr_o, 32'h10);
      tick; chk_st("t4_halt_hold", ST_HALT, 0, 0, 0);
      halt_i = 1'b0;
      tick; chk_st("t4_resume", ST_FETCH, 1, 0, 0);
      chk("t4_addr", imem_addr_o, 32'h10);
      chk("t4_ret", retire_cnt_o, 32'd4);
      // reset during READ
      imem_ack_i = 1'b1;
      tick; imem_ack_i = 1'b0;
      tick; chk_st("t5_read", ST_READ, 0, 1, 0);
      reset = 1'b1;
      tick; chk_st("t5_rst_ctl", ST_FETCH, 0, 0, 0);
      chk("t5_pc", imem_addr_o, 32'h0);
      chk("t5_ir", ir_o, 32'h0);
      chk("t5_ret", retire_cnt_o, 32'h0);
      chk("t5_flags", {30'd0, illegal_o, fault_o}, 32'h0);
      reset = 1'b0;
      tick; chk_st("t5_req", ST_FETCH, 1, 0, 0);
      // no ack for 15 fetch cycles
      repeat (14) tick;
      chk_st("t6_last_wait", ST_FETCH, 1, 0, 0);
      chk("t6_no_fault", {31'd0, fault_o}, 32'd0);
      tick; chk_st("t6_fault", ST_FAULT, 0, 0, 0);
      chk("t6_fault_flag", {31'd0, fault_o}, 32'd1);
      imem_ack_i = 1'b1;
      tick; tick;
      chk_st("t6_fault_hold", ST_FAULT, 0, 0, 0);
      chk("t6_fault_sticky", {31'd0, fault_o}, 32'd1);
      imem_ack_i = 1'b0;
      // ack on the last allowed cycle wins over timeout
      reset = 1'b1;
      tick; reset = 1'b0;
      tick; repeat (14) tick;
      imem_data_i = ADDI; imem_ack_i = 1'b1;
      tick; chk_st("t7_ack_wins", ST_DECODE, 0, 0, 0);
      chk("t7_fault", {31'd0, fault_o}, 32'd0);
      chk("t7_ir", ir_o, ADDI);
      imem_ack_i = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
